// File: rtl/level_pkg.sv
`default_nettype none
// ============================================================================
// Module      : level_pkg
// Description : Shared level-map geometry, collision probe indices, probe FSM
//               state encoding and the result record type.
// Revision    : 1.0 - initial release
// ============================================================================
package level_pkg;

  // Level map geometry in screen pixels
  localparam int GRID_SIZE = 32;
  localparam int MAP_LEFT  = 143;
  localparam int MAP_TOP   = 34;
  localparam int ROW_MAX   = 15;
  localparam int COL_MAX   = 19;

  // Probe order; the index doubles as the result bit position
  localparam logic [2:0] PRB_TL = 3'd0;
  localparam logic [2:0] PRB_TR = 3'd1;
  localparam logic [2:0] PRB_BL = 3'd2;
  localparam logic [2:0] PRB_BR = 3'd3;
  localparam logic [2:0] PRB_GL = 3'd4;
  localparam logic [2:0] PRB_GR = 3'd5;

  // Probe sequencer states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PROBE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef struct packed {
    logic [3:0] hit;        // {BR,BL,TR,TL}
    logic       on_ground;  // GL | GR
  } probe_result_t;

endpackage
`default_nettype wire

// File: rtl/collision_probe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : collision_probe_ctrl_if
// Description : Query handshake from the physics FSM plus the level map
//               collision read port, bundled for the probe sequencer.
//               master = physics FSM / map side, slave = probe sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface collision_probe_ctrl_if #(
  parameter int COORD_W = 10
);
  logic               req;
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic               busy;
  logic               done;
  logic [3:0]         hit;
  logic               on_ground;
  logic [COORD_W-1:0] probe_x;
  logic [COORD_W-1:0] probe_y;
  logic               probe_data;

  modport master (
    output req, pos_x, pos_y, probe_data,
    input  busy, done, hit, on_ground, probe_x, probe_y
  );

  modport slave (
    input  req, pos_x, pos_y, probe_data,
    output busy, done, hit, on_ground, probe_x, probe_y
  );
endinterface
`default_nettype wire

// File: rtl/collision_probe_ctrl_probe_point_gen.sv
`default_nettype none
// ============================================================================
// Module      : probe_point_gen
// Description : Maps a probe index and sprite top-left position to the probe
//               point. Offsets are added one bit wider than the coordinate and
//               saturate to all-ones so an overflowing point lands off-map
//               (reported solid) instead of wrapping to the left/top edge.
// Revision    : 1.0 - initial release
// ============================================================================
module probe_point_gen
  import level_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int SPR_W   = 32,
  parameter int SPR_H   = 32
) (
  input  logic [2:0]         idx,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py
);

  localparam logic [COORD_W:0] c_dx_right  = (COORD_W+1)'(SPR_W - 1);
  localparam logic [COORD_W:0] c_dy_bottom = (COORD_W+1)'(SPR_H - 1);
  localparam logic [COORD_W:0] c_dy_ground = (COORD_W+1)'(SPR_H);

  function automatic logic [COORD_W-1:0] sat_add(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W:0]   b);
    logic [COORD_W:0] s;
    s = {1'b0, a} + b;
    return s[COORD_W] ? {COORD_W{1'b1}} : s[COORD_W-1:0];
  endfunction

  logic [COORD_W-1:0] w_right;
  logic [COORD_W-1:0] w_bottom;
  logic [COORD_W-1:0] w_ground;

  // Saturated edge coordinates shared by the six probe points
  always_comb begin
    w_right  = sat_add(x, c_dx_right);
    w_bottom = sat_add(y, c_dy_bottom);
    w_ground = sat_add(y, c_dy_ground);
  end

  // Select the point for the requested probe index
  always_comb begin
    px = x;
    py = y;
    case (idx)
      PRB_TL: begin px = x;       py = y;        end
      PRB_TR: begin px = w_right; py = y;        end
      PRB_BL: begin px = x;       py = w_bottom; end
      PRB_BR: begin px = w_right; py = w_bottom; end
      PRB_GL: begin px = x;       py = w_ground; end
      PRB_GR: begin px = w_right; py = w_ground; end
      default: begin px = x;      py = y;        end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/collision_probe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : collision_probe_ctrl
// Description : Sequences six collision probes for one sprite over the level
//               map collision port and reports corner hits and on-ground.
//               Results only change on the PROBE->DONE edge.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_probe_ctrl
  import level_pkg::*;
#(
  parameter int SPR_W   = 32,
  parameter int SPR_H   = 32,
  parameter int COORD_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  collision_probe_ctrl_if.slave  bus
);

  logic [1:0]         r_state;
  logic [2:0]         r_idx;
  logic [COORD_W-1:0] r_pos_x;
  logic [COORD_W-1:0] r_pos_y;
  logic [4:0]         r_work;      // samples for TL..GL; GR is folded in directly
  probe_result_t      r_result;
  logic               r_busy;
  logic               r_done;
  logic [COORD_W-1:0] r_probe_x;
  logic [COORD_W-1:0] r_probe_y;

  logic [2:0]         w_gen_idx;
  logic [COORD_W-1:0] w_gen_x;
  logic [COORD_W-1:0] w_gen_y;
  logic [COORD_W-1:0] w_px;
  logic [COORD_W-1:0] w_py;

  // In IDLE the first point comes from the live position so it can be driven on
  // the accept edge; during PROBE the latched position and next index are used
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_gen_idx = PRB_TL;
      w_gen_x   = bus.pos_x;
      w_gen_y   = bus.pos_y;
    end else begin
      w_gen_idx = r_idx + 3'd1;
      w_gen_x   = r_pos_x;
      w_gen_y   = r_pos_y;
    end
  end

  probe_point_gen #(
    .COORD_W (COORD_W),
    .SPR_W   (SPR_W),
    .SPR_H   (SPR_H)
  ) u_point_gen (
    .idx (w_gen_idx),
    .x   (w_gen_x),
    .y   (w_gen_y),
    .px  (w_px),
    .py  (w_py)
  );

  // Probe sequencer: accept, step through six points, publish results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= 3'd0;
      r_pos_x   <= '0;
      r_pos_y   <= '0;
      r_work    <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_probe_x <= '0;
      r_probe_y <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req) begin
            r_pos_x   <= bus.pos_x;
            r_pos_y   <= bus.pos_y;
            r_idx     <= PRB_TL;
            r_work    <= '0;
            r_probe_x <= w_px;
            r_probe_y <= w_py;
            r_busy    <= 1'b1;
            r_state   <= ST_PROBE;
          end
        end
        ST_PROBE: begin
          if (r_idx == PRB_GR) begin
            r_result.hit       <= r_work[3:0];
            r_result.on_ground <= r_work[PRB_GL] | bus.probe_data;
            r_busy             <= 1'b0;
            r_done             <= 1'b1;
            r_state            <= ST_DONE;
          end else begin
            r_work[r_idx] <= bus.probe_data;
            r_idx         <= r_idx + 3'd1;
            r_probe_x     <= w_px;
            r_probe_y     <= w_py;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.hit       = r_result.hit;
  assign bus.on_ground = r_result.on_ground;
  assign bus.probe_x   = r_probe_x;
  assign bus.probe_y   = r_probe_y;

endmodule
`default_nettype wire

// File: tb/tb_collision_probe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_collision_probe_ctrl
// Description : Self-checking bench for collision_probe_ctrl with a
//               behavioural tile map and a point/hit reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_probe_ctrl;
  import level_pkg::*;

  localparam int COORD_W = 10;
  localparam int SPR_W   = 32;
  localparam int SPR_H   = 32;
  localparam int CMAX    = (1 << COORD_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  collision_probe_ctrl_if #(.COORD_W(COORD_W)) bus ();

  collision_probe_ctrl #(
    .SPR_W   (SPR_W),
    .SPR_H   (SPR_H),
    .COORD_W (COORD_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bit         map_bits [0:ROW_MAX][0:COL_MAX];
  int         map_ver = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] prev_hit = 4'd0;
  logic       prev_og = 1'b0;
  int         min_px;

  // Behavioural map: solid outside the grid or where a tile bit is set
  function automatic bit solid(input int px, input int py);
    int col, row;
    if (px < MAP_LEFT || py < MAP_TOP) return 1'b1;
    col = (px - MAP_LEFT) / GRID_SIZE;
    row = (py - MAP_TOP) / GRID_SIZE;
    if (col > COL_MAX || row > ROW_MAX) return 1'b1;
    return map_bits[row][col];
  endfunction

  always @(bus.probe_x or bus.probe_y or map_ver)
    bus.probe_data = solid(int'(bus.probe_x), int'(bus.probe_y));

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model(input int x, input int y, output int ex[6], output int ey[6],
                       output logic [3:0] eh, output logic eog);
    int r, b, g;
    r = sat(x + SPR_W - 1);
    b = sat(y + SPR_H - 1);
    g = sat(y + SPR_H);
    ex = '{x, r, x, r, x, r};
    ey = '{y, y, b, b, g, g};
    for (int k = 0; k < 4; k++) eh[k] = solid(ex[k], ey[k]);
    eog = solid(ex[4], ey[4]) | solid(ex[5], ey[5]);
  endtask

  task automatic clear_map();
    for (int r = 0; r <= ROW_MAX; r++)
      for (int c = 0; c <= COL_MAX; c++) map_bits[r][c] = 1'b0;
    map_ver++;
  endtask

  task automatic fill_map(input int pct);
    for (int r = 0; r <= ROW_MAX; r++)
      for (int c = 0; c <= COL_MAX; c++) map_bits[r][c] = ($urandom_range(0, 99) < pct);
    map_ver++;
  endtask

  // One full query: probes, busy/done timing, result hold and publish
  task automatic run_query(input int x, input int y, input string tag);
    int ex[6], ey[6];
    logic [3:0] eh;
    logic eog;
    model(x, y, ex, ey, eh, eog);
    @(negedge clk);
    bus.req = 1'b1;
    bus.pos_x = COORD_W'(x);
    bus.pos_y = COORD_W'(y);
    @(negedge clk);
    bus.req = 1'b0;
    bus.pos_x = COORD_W'($urandom);
    bus.pos_y = COORD_W'($urandom);
    min_px = CMAX;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if ({bus.busy, bus.done, bus.probe_x, bus.probe_y} !==
          {1'b1, 1'b0, COORD_W'(ex[k]), COORD_W'(ey[k])}) begin
        n_fail++;
        $display("FAIL %s probe%0d: busy=%b done=%b pt=(%0d,%0d) required busy=1 done=0 pt=(%0d,%0d)",
                 tag, k, bus.busy, bus.done, bus.probe_x, bus.probe_y, ex[k], ey[k]);
      end
      n_checks++;
      if ({bus.hit, bus.on_ground} !== {prev_hit, prev_og}) begin
        n_fail++;
        $display("FAIL %s hold%0d: hit=%b og=%b required hit=%b og=%b",
                 tag, k, bus.hit, bus.on_ground, prev_hit, prev_og);
      end
      if (int'(bus.probe_x) < min_px) min_px = int'(bus.probe_x);
      @(negedge clk);
    end
    n_checks++;
    if ({bus.busy, bus.done, bus.hit, bus.on_ground} !== {1'b0, 1'b1, eh, eog}) begin
      n_fail++;
      $display("FAIL %s result: busy=%b done=%b hit=%b og=%b required busy=0 done=1 hit=%b og=%b",
               tag, bus.busy, bus.done, bus.hit, bus.on_ground, eh, eog);
    end
    n_checks++;
    if ({bus.probe_x, bus.probe_y} !== {COORD_W'(ex[5]), COORD_W'(ey[5])}) begin
      n_fail++;
      $display("FAIL %s probe_hold: pt=(%0d,%0d) required (%0d,%0d)",
               tag, bus.probe_x, bus.probe_y, ex[5], ey[5]);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.done, bus.hit, bus.on_ground} !== {1'b0, eh, eog}) begin
      n_fail++;
      $display("FAIL %s done_pulse: done=%b hit=%b og=%b required done=0 hit=%b og=%b",
               tag, bus.done, bus.hit, bus.on_ground, eh, eog);
    end
    prev_hit = eh;
    prev_og  = eog;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 1'b0;
    bus.pos_x = '0;
    bus.pos_y = '0;
    clear_map();
    #12;
    n_checks++;
    if ({bus.busy, bus.done, bus.hit, bus.on_ground, bus.probe_x, bus.probe_y} !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b hit=%b og=%b pt=(%0d,%0d) required all zero",
               bus.busy, bus.done, bus.hit, bus.on_ground, bus.probe_x, bus.probe_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_empty();
    clear_map();
    run_query(300, 200, "empty");
    n_checks++;
    if ({bus.hit, bus.on_ground} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL empty_literal: hit=%b og=%b required 0000 0", bus.hit, bus.on_ground);
    end
  endtask

  task automatic test_floor();
    clear_map();
    for (int c = 0; c <= COL_MAX; c++) map_bits[10][c] = 1'b1;
    map_ver++;
    run_query(300, 322, "floor_stand");
    n_checks++;
    if ({bus.hit, bus.on_ground} !== 5'b0000_1) begin
      n_fail++;
      $display("FAIL floor_stand_literal: hit=%b og=%b required 0000 1", bus.hit, bus.on_ground);
    end
    run_query(300, 330, "floor_sunk");
    n_checks++;
    if ({bus.hit, bus.on_ground} !== 5'b1100_1) begin
      n_fail++;
      $display("FAIL floor_sunk_literal: hit=%b og=%b required 1100 1", bus.hit, bus.on_ground);
    end
  endtask

  task automatic test_saturate();
    clear_map();
    run_query(1000, 470, "saturate");
    n_checks++;
    if ({bus.hit, bus.on_ground} !== 5'b1111_1) begin
      n_fail++;
      $display("FAIL saturate_literal: hit=%b og=%b required 1111 1", bus.hit, bus.on_ground);
    end
    n_checks++;
    if (min_px < 1000) begin
      n_fail++;
      $display("FAIL saturate_nowrap: min probe_x=%0d required >=1000", min_px);
    end
  endtask

  // Column 5 covers x 303..334: TL/BL at x=287 sit in column 4, TR/BR/GR at x=318 in column 5
  task automatic test_wall();
    clear_map();
    for (int r = 0; r <= ROW_MAX; r++) map_bits[r][5] = 1'b1;
    map_ver++;
    run_query(MAP_LEFT + 5 * GRID_SIZE - 16, 100, "wall");
    n_checks++;
    if ({bus.hit, bus.on_ground} !== 5'b1010_1) begin
      n_fail++;
      $display("FAIL wall_literal: hit=%b og=%b required 1010 1", bus.hit, bus.on_ground);
    end
  endtask

  task automatic test_back_to_back();
    int ax, ay, bx, by;
    int exa[6], eya[6], exb[6], eyb[6];
    logic [3:0] eha, ehb;
    logic oga, ogb;
    bit exp_busy, exp_done;
    fill_map(30);
    ax = $urandom_range(100, 700); ay = $urandom_range(20, 500);
    bx = $urandom_range(100, 700); by = $urandom_range(20, 500);
    model(ax, ay, exa, eya, eha, oga);
    model(bx, by, exb, eyb, ehb, ogb);
    @(negedge clk);
    bus.req = 1'b1;
    bus.pos_x = COORD_W'(ax);
    bus.pos_y = COORD_W'(ay);
    for (int n = 1; n <= 23; n++) begin
      @(negedge clk);
      exp_busy = ((n % 8) >= 1) && ((n % 8) <= 6);
      exp_done = ((n % 8) == 7);
      n_checks++;
      if ({bus.busy, bus.done} !== {exp_busy, exp_done}) begin
        n_fail++;
        $display("FAIL b2b_timing n=%0d: busy=%b done=%b required busy=%b done=%b",
                 n, bus.busy, bus.done, exp_busy, exp_done);
      end
      if (n == 1 || n == 4) begin
        n_checks++;
        if ({bus.probe_x, bus.probe_y} !== {COORD_W'(exa[n-1]), COORD_W'(eya[n-1])}) begin
          n_fail++;
          $display("FAIL b2b_latch n=%0d: pt=(%0d,%0d) required (%0d,%0d)",
                   n, bus.probe_x, bus.probe_y, exa[n-1], eya[n-1]);
        end
      end
      if (n == 7 || n == 15) begin
        n_checks++;
        if ({bus.hit, bus.on_ground} !== ((n == 7) ? {eha, oga} : {ehb, ogb})) begin
          n_fail++;
          $display("FAIL b2b_result n=%0d: hit=%b og=%b required %b",
                   n, bus.hit, bus.on_ground, (n == 7) ? {eha, oga} : {ehb, ogb});
        end
      end
      if (n == 3) begin
        bus.pos_x = COORD_W'(bx);
        bus.pos_y = COORD_W'(by);
      end
      if (n == 23) bus.req = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_release: busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
    prev_hit = ehb;
    prev_og  = ogb;
  endtask

  task automatic test_reset_mid();
    int ex[6], ey[6];
    logic [3:0] eh;
    logic eog;
    bit saw;
    fill_map(40);
    model(400, 150, ex, ey, eh, eog);
    @(negedge clk);
    bus.req = 1'b1;
    bus.pos_x = COORD_W'(400);
    bus.pos_y = COORD_W'(150);
    @(negedge clk);
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.probe_x, bus.probe_y} !== {1'b1, COORD_W'(ex[3]), COORD_W'(ey[3])}) begin
      n_fail++;
      $display("FAIL rstmid_pre: busy=%b pt=(%0d,%0d) required busy=1 pt=(%0d,%0d)",
               bus.busy, bus.probe_x, bus.probe_y, ex[3], ey[3]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.hit, bus.on_ground, bus.probe_x, bus.probe_y} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_clear: busy=%b done=%b hit=%b og=%b pt=(%0d,%0d) required all zero",
               bus.busy, bus.done, bus.hit, bus.on_ground, bus.probe_x, bus.probe_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev_hit = 4'd0;
    prev_og  = 1'b0;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_nodone: activity=%b required 0", saw);
    end
    run_query(400, 150, "rstmid_after");
  endtask

  task automatic test_random();
    int x, y;
    for (int i = 0; i < 20; i++) begin
      fill_map(25);
      case ($urandom_range(0, 3))
        0: x = 0;
        1: x = CMAX - $urandom_range(0, 40);
        default: x = $urandom_range(0, CMAX);
      endcase
      y = ($urandom_range(0, 4) == 0) ? CMAX - $urandom_range(0, 40) : $urandom_range(0, CMAX);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_query(x, y, "random");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_empty();
    test_floor();
    test_saturate();
    test_wall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
